// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types and widths for the ID/EX boundary.
// No logic: widths, the ID/EX record layout and the bubble constant.
// The bubble constant is all-zero so a killed slot carries ex_valid=0.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_W    = 5;
  localparam int ALU_OP_W = 4;

  // One decoded instruction as it crosses the ID/EX register.
  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_wb;
    logic                wb_sel;
    logic                mem_wr;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load in EX whose rd feeds the ID instruction.
// Latency: purely combinational.
// Backpressure: none itself; its output is folded into the ID/EX hold logic.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_wb_sel,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  // x0 is hardwired zero, so a load targeting it never produces a dependency.
  assign load_use = id_valid & ex_valid & ex_wb_sel & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, external hold and load-use bubble insertion.
// Latency: one cycle from id_* to ex_*; a load-use hazard adds one bubble cycle.
// Backpressure: stall_if_id holds PC and IF/ID; stall_ext freezes the EX register.
// Build option ID_EX_LOAD_USE_STALL_EN enables the load-use hazard interlock.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_ext,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_reg_WB,
  input  logic                id_WB_sel,
  input  logic                id_mem_wr,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [REG_W-1:0]    ex_rs1,
  output logic [REG_W-1:0]    ex_rs2,
  output logic [REG_W-1:0]    ex_rd,
  output logic [XLEN-1:0]     ex_rs1_data,
  output logic [XLEN-1:0]     ex_rs2_data,
  output logic [XLEN-1:0]     ex_imm,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_reg_WB,
  output logic                ex_WB_sel,
  output logic                ex_mem_wr,
  output logic                stall_if_id
);

  id_ex_t id_rec;
  id_ex_t ex_d;
  id_ex_t ex_q;
  logic   load_use;

  assign id_rec = '{valid:    id_valid,
                    pc:       id_pc,
                    rs1:      id_rs1,
                    rs2:      id_rs2,
                    rd:       id_rd,
                    rs1_data: id_rs1_data,
                    rs2_data: id_rs2_data,
                    imm:      id_imm,
                    alu_op:   id_alu_op,
                    reg_wb:   id_reg_WB,
                    wb_sel:   id_WB_sel,
                    mem_wr:   id_mem_wr};

`ifdef ID_EX_LOAD_USE_STALL_EN
  load_use_detect u_load_use_detect (
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .ex_valid  (ex_q.valid),
    .ex_wb_sel (ex_q.wb_sel),
    .ex_rd     (ex_q.rd),
    .load_use  (load_use)
  );
`else
  // Toolchain schedules nops after loads, so no interlock is needed.
  assign load_use = 1'b0;
`endif

  // Next EX contents: flush beats hold, hold beats the load-use bubble.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = ID_EX_BUBBLE;
    end else if (stall_ext) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = ID_EX_BUBBLE;
    end else begin
      ex_d = id_rec;
    end
  end

  // EX register; reset discards anything held during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  // A flush replaces the ID instruction anyway, so it must not hold IF/ID.
  assign stall_if_id = ~rst & (stall_ext | (load_use & ~flush));

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_alu_op   = ex_q.alu_op;
  assign ex_reg_WB   = ex_q.reg_wb;
  assign ex_WB_sel   = ex_q.wb_sel;
  assign ex_mem_wr   = ex_q.mem_wr;

endmodule
